pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the processor fetch stage.
- Successor to the fixed 16-bit PC: configurable width and reset vector, a runtime conditional-jump target instead of a hardcoded loop address, a stall input, and a hardware call/return stack of configurable depth.
- Drives the instruction-memory address each cycle.
- Accepts control from the decoder and the ALU zero flag.

Parameters:
- PC_WIDTH, 16, width of the PC, jump target and stack entries.
- RESET_VECTOR, 0, PC value loaded on reset; truncated to PC_WIDTH.
- STACK_DEPTH, 4, number of return-address entries; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  freeze PC and stack this cycle.
- inc  input  1  advance PC by 1.
- jump  input  1  conditional jump request; taken only when Z=1.
- Z  input  1  ALU zero flag.
- call  input  1  unconditional call: push PC+1, load jump_target.
- ret  input  1  return: pop the stack into the PC.
- jump_target  input  PC_WIDTH  target address for jump and call.
- pc_result  output  PC_WIDTH  current PC (registered).
- stack_full  output  1  stack holds STACK_DEPTH entries (combinational from the count).
- stack_empty  output  1  stack holds 0 entries.
- stack_err  output  1  sticky overflow/underflow flag; cleared only by reset.

Behaviour:
- Reset (synchronous, highest priority): pc_result=RESET_VECTOR, stack count=0, stack_err=0. Outputs after reset: stack_empty=1, stack_full=0. Stack contents are don't-care.
- Priority per cycle when reset=0: stall > ret > call > (jump & Z) > inc > hold.
- stall=1: PC, stack and stack_err all hold; every other input is ignored.
- ret with count>0: pc_result <= top entry; count decrements.
- ret with count=0 (underflow): PC holds; stack_err <= 1.
- call with count<STACK_DEPTH: push pc_result+1 (mod 2^PC_WIDTH); pc_result <= jump_target; count increments.
- call with count=STACK_DEPTH (overflow): no push, PC holds, stack_err <= 1.
- jump & Z: pc_result <= jump_target.
- jump & ~Z: not taken; falls through to inc/hold.
- inc: pc_result <= pc_result+1, wrapping from all-ones to 0 with no flag.
- None of the above: hold.
- Simultaneous call and ret: ret wins; call is ignored and nothing is pushed.
- Latency: every action takes effect on the next posedge; no combinational path from inputs to pc_result.
- Stack is LIFO and implemented as registers indexed by count. Count width is clog2(STACK_DEPTH+1).
- stack_err stays set once set; all later operations proceed normally.
- Reset asserted mid-sequence (e.g. during a call) discards the in-flight operation; the reset values win that edge.

Optional Feature:
- Macro PC_REL_JUMP_EN.
- Defined: jump and call targets are relative. New PC = pc_result + jump_target, with jump_target treated as two's-complement and summed mod 2^PC_WIDTH. The return address pushed by call is still pc_result+1.
- Not defined: jump_target is an absolute address.
- Ports are identical in both builds.

Test Plan:
- Reset then inc=1 for 3 cycles (PC_WIDTH=16, RESET_VECTOR=0) -> pc_result 0,1,2,3; stack_empty=1, stack_err=0.
- pc_result=0x0010, jump=1, Z=0, inc=1 -> 0x0011. Then jump=1, Z=1, jump_target=0x0003 -> 0x0003 (with PC_REL_JUMP_EN: 0x0014).
- pc_result=0x0020, call, jump_target=0x0100 -> pc=0x0100, stack_empty=0. Then ret -> pc=0x0021, stack_empty=1.
- STACK_DEPTH=4: five consecutive calls -> stack_full=1 after the 4th; 5th leaves PC unchanged and sets stack_err=1. Four rets unwind correctly; a 5th ret holds PC with stack_err still 1.
- pc_result=0xFFFF, inc=1 -> 0x0000. stall=1 together with inc, call and ret -> PC and count unchanged.
- call and ret asserted in the same cycle with 1 entry on the stack -> pop only, count=0. Then reset asserted together with call -> pc=RESET_VECTOR, count=0, stack_err=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage with conditional jump, stall and a call/return stack.
// Define PC_REL_JUMP_EN to make jump/call targets PC-relative (two's-complement offset).
module pc_sequencer #(
  parameter int PC_WIDTH     = 16,
  parameter int RESET_VECTOR = 0,
  parameter int STACK_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                inc,
  input  logic                jump,
  input  logic                Z,
  input  logic                call,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic [PC_WIDTH-1:0] pc_result,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                stack_err
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam logic [CW-1:0]       DEPTH_C  = CW'(STACK_DEPTH);
  localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_VECTOR);

  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [CW-1:0]       count_reg, count_next;
  logic                err_reg, err_next;
  logic                push;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] ret_addr;
  logic [PC_WIDTH-1:0] top_entry;
  logic [PC_WIDTH-1:0] stack_word [STACK_DEPTH];

`ifdef PC_REL_JUMP_EN
  assign target = pc_reg + jump_target;
`else
  assign target = jump_target;
`endif

  assign ret_addr = pc_reg + PC_WIDTH'(1);

  // Entry gi is written when it is the next free slot, i.e. count == gi.
  generate
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      logic [PC_WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (!reset && push && count_reg == CW'(gi))
          entry_reg <= ret_addr;
      end
      assign stack_word[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    top_entry = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (count_reg == CW'(i + 1))
        top_entry = stack_word[i];
    end
  end

  always_comb begin
    pc_next    = pc_reg;
    count_next = count_reg;
    err_next   = err_reg;
    push       = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (count_reg != '0) begin
          pc_next    = top_entry;
          count_next = count_reg - CW'(1);
        end else begin
          err_next = 1'b1;
        end
      end else if (call) begin
        if (count_reg != DEPTH_C) begin
          push       = 1'b1;
          pc_next    = target;
          count_next = count_reg + CW'(1);
        end else begin
          err_next = 1'b1;
        end
      end else if (jump && Z) begin
        pc_next = target;
      end else if (inc) begin
        pc_next = pc_reg + PC_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  assign pc_result   = pc_reg;
  assign stack_full  = (count_reg == DEPTH_C);
  assign stack_empty = (count_reg == '0);
  assign stack_err   = err_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer at default parameters (16-bit, reset 0, depth 4).
// Expected PCs adapt to PC_REL_JUMP_EN so the same table serves both builds.
module tb_pc_sequencer;

`ifdef PC_REL_JUMP_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, inc, jump, Z, call, ret;
  logic [15:0] jump_target;
  logic [15:0] pc_result;
  logic        stack_full, stack_empty, stack_err;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(.PC_WIDTH(16), .RESET_VECTOR(0), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .inc(inc), .jump(jump), .Z(Z),
    .call(call), .ret(ret), .jump_target(jump_target), .pc_result(pc_result),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, inc, jmp, z, cal, rt;
    logic [15:0] tgt;
    logic [15:0] pc;
    logic        full, empty, err;
  } vec_t;

  vec_t tbl[$];

  // Target operand that lands on dest from pc in either addressing mode.
  function automatic logic [15:0] tg(input logic [15:0] pc, input logic [15:0] dest);
    return REL ? (dest - pc) : dest;
  endfunction

  task automatic add(input logic r, st, i, j, z, c, rt, input logic [15:0] t,
                     input logic [15:0] p, input logic f, e, er);
    vec_t v;
    v.rst = r; v.stl = st; v.inc = i; v.jmp = j; v.z = z; v.cal = c; v.rt = rt;
    v.tgt = t; v.pc = p; v.full = f; v.empty = e; v.err = er;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", name, row, got, want);
    end
  endtask

  localparam logic [15:0] P7 = REL ? 16'h0014 : 16'h0003;

  initial begin
    reset = 1'b1; stall = 1'b0; inc = 1'b0; jump = 1'b0; Z = 1'b0;
    call = 1'b0; ret = 1'b0; jump_target = '0;

    //   rst st inc jmp z cal ret  tgt                    pc       full empty err
    add(1, 0, 0, 0, 0, 0, 0, 16'h0000,               16'h0000, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 16'h0000,               16'h0001, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 16'h0000,               16'h0002, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 16'h0000,               16'h0003, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0, 0, tg(16'h0003, 16'h0010), 16'h0010, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0, 16'h0055,               16'h0011, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0, 0, 16'h0003,               P7,       0, 1, 0);
    add(0, 0, 0, 1, 1, 0, 0, tg(P7, 16'h0020),       16'h0020, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, tg(16'h0020, 16'h0100), 16'h0100, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000,               16'h0021, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000,               16'h0021, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 16'h0000,               16'h0000, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, tg(16'h0000, 16'h0040), 16'h0040, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, tg(16'h0040, 16'h0080), 16'h0080, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, tg(16'h0080, 16'h00C0), 16'h00C0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, tg(16'h00C0, 16'h0200), 16'h0200, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, tg(16'h0200, 16'h0300), 16'h0200, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000,               16'h00C1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000,               16'h0081, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000,               16'h0041, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000,               16'h0001, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000,               16'h0001, 0, 1, 1);
    add(0, 0, 0, 1, 1, 0, 0, tg(16'h0001, 16'hFFFF), 16'hFFFF, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 16'h0000,               16'h0000, 0, 1, 1);
    add(0, 1, 1, 1, 1, 1, 1, 16'h1234,               16'h0000, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, tg(16'h0000, 16'h0500), 16'h0500, 0, 0, 1);
    add(0, 1, 1, 1, 1, 1, 1, 16'h0777,               16'h0500, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 16'h0999,               16'h0001, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 0, 16'h0700,               16'h0000, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 16'h0000,               16'h0000, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000,               16'h0000, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 16'h0000,               16'h0001, 0, 1, 1);

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      reset = tbl[r].rst; stall = tbl[r].stl; inc = tbl[r].inc; jump = tbl[r].jmp;
      Z = tbl[r].z; call = tbl[r].cal; ret = tbl[r].rt; jump_target = tbl[r].tgt;
      @(posedge clk);
      #1;
      $display("row %0d rst=%b stl=%b inc=%b jmp=%b z=%b cal=%b ret=%b tgt=%h -> pc=%h full=%b empty=%b err=%b",
               r, reset, stall, inc, jump, Z, call, ret, jump_target,
               pc_result, stack_full, stack_empty, stack_err);
      chk("pc",    r, pc_result,          tbl[r].pc);
      chk("full",  r, 16'(stack_full),    16'(tbl[r].full));
      chk("empty", r, 16'(stack_empty),   16'(tbl[r].empty));
      chk("err",   r, 16'(stack_err),     16'(tbl[r].err));
    end

    // Input changes must not reach pc_result before the next edge.
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0;
    jump = 1'b1; Z = 1'b1; jump_target = 16'h1234;
    #1;
    $display("comb-path probe pc=%h", pc_result);
    chk("no_comb_path", 100, pc_result, 16'h0001);
    @(posedge clk);
    #1;
    $display("jump after probe pc=%h", pc_result);
    chk("jump_after_probe", 101, pc_result, REL ? 16'h1235 : 16'h1234);
    jump = 1'b0; Z = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
